shift_pipe_unit: RTL and testbench

Parametrised, pipelined barrel shifter for the MIPS datapath, generalising the fixed constant left-shift. Performs SLL/SRL/SRA/ROTR by a variable amount across SHAMT_W registered stages, one stage per shift-amount bit, with full per-cycle throughput. Carries a destination tag alongside each operation for writeback/forwarding. Supports pipeline stall and flush from hazard control.

---
 rtl/shift_pipe_unit_if.sv | 29 ++
 rtl/shift_pipe_unit.sv | 105 ++++++++++
 tb/tb_shift_pipe_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_pipe_unit_if.sv
// Operand/result bundle for the pipelined barrel shifter, including the
// hazard-control lines (stall/flush) and the pipeline-occupancy flag.
interface shift_pipe_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
);
    logic               stall;
    logic               flush;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    modport master (
        output stall, flush, in_valid, in_data, in_shamt, in_mode, in_tag,
        input  out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  stall, flush, in_valid, in_data, in_shamt, in_mode, in_tag,
        output out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/shift_pipe_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR): stage k shifts by 2^k when
// shamt bit k is set; tag, mode, sign and valid travel with the data.
module shift_pipe_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    shift_pipe_unit_if.slave sp
);
    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;

    logic               vld_p   [SHAMT_W];
    logic [WIDTH-1:0]   data_p  [SHAMT_W];
    logic [SHAMT_W-1:0] shamt_p [SHAMT_W];
    logic [1:0]         mode_p  [SHAMT_W];
    logic [TAG_W-1:0]   tag_p   [SHAMT_W];
    logic               sign_p  [SHAMT_W];

    logic               src_vld   [SHAMT_W];
    logic [WIDTH-1:0]   src_data  [SHAMT_W];
    logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
    logic [1:0]         src_mode  [SHAMT_W];
    logic [TAG_W-1:0]   src_tag   [SHAMT_W];
    logic               src_sign  [SHAMT_W];
    logic [WIDTH-1:0]   res       [SHAMT_W];
    logic               busy_c;

    // SRA fills from the sign captured at the input, not the current MSB.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int unsigned      amt,
        input logic [1:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] fill;
        fill = {WIDTH{sign}} << (WIDTH - amt);
        case (mode)
            MODE_SLL: shift_step = d << amt;
            MODE_SRL: shift_step = d >> amt;
            MODE_SRA: shift_step = (d >> amt) | fill;
            default:  shift_step = (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    always_comb begin
        src_vld[0]   = sp.in_valid;
        src_data[0]  = sp.in_data;
        src_shamt[0] = sp.in_shamt;
        src_mode[0]  = sp.in_mode;
        src_tag[0]   = sp.in_tag;
        src_sign[0]  = sp.in_data[WIDTH-1];
        for (int k = 1; k < SHAMT_W; k++) begin
            src_vld[k]   = vld_p[k-1];
            src_data[k]  = data_p[k-1];
            src_shamt[k] = shamt_p[k-1];
            src_mode[k]  = mode_p[k-1];
            src_tag[k]   = tag_p[k-1];
            src_sign[k]  = sign_p[k-1];
        end
        for (int k = 0; k < SHAMT_W; k++) begin
            res[k] = src_shamt[k][k]
                   ? shift_step(src_data[k], 1 << k, src_mode[k], src_sign[k])
                   : src_data[k];
        end
    end

    // Stage registers: bubbles load zero so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst || sp.flush) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                vld_p[k]   <= 1'b0;
                data_p[k]  <= '0;
                shamt_p[k] <= '0;
                mode_p[k]  <= '0;
                tag_p[k]   <= '0;
                sign_p[k]  <= 1'b0;
            end
        end else if (!sp.stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                vld_p[k]   <= src_vld[k];
                data_p[k]  <= src_vld[k] ? res[k]       : '0;
                shamt_p[k] <= src_vld[k] ? src_shamt[k] : '0;
                mode_p[k]  <= src_vld[k] ? src_mode[k]  : '0;
                tag_p[k]   <= src_vld[k] ? src_tag[k]   : '0;
                sign_p[k]  <= src_vld[k] ? src_sign[k]  : 1'b0;
            end
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k < SHAMT_W; k++) begin
            busy_c = busy_c | vld_p[k];
        end
    end

    assign sp.out_valid = vld_p[SHAMT_W-1];
    assign sp.out_data  = data_p[SHAMT_W-1];
    assign sp.out_tag   = tag_p[SHAMT_W-1];
    assign sp.busy      = busy_c;
endmodule

// File: tb/tb_shift_pipe_unit.sv
// Scoreboard bench for shift_pipe_unit: stimulus queues expected results with
// their arrival cycle; a negedge monitor pops and compares each output.
module tb_shift_pipe_unit;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 5;
    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROTR = 2'b11;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] t;
        int               c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    shift_pipe_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) sp ();

    shift_pipe_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst(rst),
        .sp (sp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sp.in_valid = 1'b0;
        sp.in_data  = '0;
        sp.in_shamt = '0;
        sp.in_mode  = '0;
        sp.in_tag   = '0;
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] d,
                         input logic [4:0] sh, input logic [4:0] t);
        sp.in_valid = 1'b1;
        sp.in_data  = d;
        sp.in_shamt = sh;
        sp.in_mode  = m;
        sp.in_tag   = t;
    endtask

    task automatic expect_res(input logic [31:0] d, input logic [4:0] t, input int lat);
        exp_t e;
        e.d = d;
        e.t = t;
        e.c = cyc + lat;
        q.push_back(e);
    endtask

    task automatic op(input logic [1:0] m, input logic [31:0] d, input logic [4:0] sh,
                      input logic [4:0] t, input logic [31:0] r);
        drive(m, d, sh, t);
        expect_res(r, t, SHAMT_W);
        step();
    endtask

    // A result is consumed at the edge where stall is low; held copies are not re-popped.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sp.out_valid === 1'b1) begin
                if (!sp.stall) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", sp.out_data, 32'h0);
                        chk("unexpected_valid", {31'b0, sp.out_valid}, 32'h0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("out_data", sp.out_data, e.d);
                        chk("out_tag", {27'b0, sp.out_tag}, {27'b0, e.t});
                        chk("out_cycle", cyc, e.c);
                    end
                end
            end else begin
                chk("idle_zero", {sp.out_valid, sp.out_tag, sp.out_data[25:0]} | sp.out_data,
                    32'h0);
            end
        end
    end

    initial begin
        sp.stall = 1'b0;
        sp.flush = 1'b0;
        idle();
        rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, sp.out_valid}, 32'h0);
        chk("rst_out_data", sp.out_data, 32'h0);
        chk("rst_out_tag", {27'b0, sp.out_tag}, 32'h0);
        chk("rst_busy", {31'b0, sp.busy}, 32'h0);

        // single SLL by the maximum amount
        op(SLL, 32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000);
        idle();
        chk("busy_inflight", {31'b0, sp.busy}, 32'h1);
        repeat (7) step();

        // back-to-back mixed modes
        op(SRA,  32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000);
        op(SRL,  32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000);
        op(ROTR, 32'h0000_00F1, 5'd4, 5'd3, 32'h1000_000F);
        op(SLL,  32'h0000_0ABC, 5'd2, 5'd4, 32'h0000_2AF0);
        // boundary amounts
        op(SRA,  32'h8000_0000, 5'd31, 5'd5, 32'hFFFF_FFFF);
        op(SRL,  32'hFFFF_FFFF, 5'd31, 5'd6, 32'h0000_0001);
        op(ROTR, 32'h0000_0001, 5'd31, 5'd8, 32'h0000_0002);
        op(ROTR, 32'h8000_0001, 5'd1,  5'd9, 32'hC000_0000);
        op(SRA,  32'h7FFF_FFF0, 5'd3,  5'd10, 32'h0FFF_FFFE);
        idle();
        repeat (7) step();

        // stall while the op is mid-pipe; pulses during stall are ignored
        drive(SLL, 32'h0000_0001, 5'd1, 5'd12);
        expect_res(32'h0000_0002, 5'd12, SHAMT_W + 3);
        step();
        idle();
        step();
        sp.stall = 1'b1;
        drive(SLL, 32'h0000_0055, 5'd0, 5'd20);
        step();
        idle();
        step();
        drive(SRL, 32'h0000_00AA, 5'd1, 5'd21);
        step();
        sp.stall = 1'b0;
        idle();
        repeat (8) step();

        // stall while the result is presented: it must be held
        drive(SLL, 32'h0000_0003, 5'd1, 5'd13);
        expect_res(32'h0000_0006, 5'd13, SHAMT_W + 2);
        step();
        idle();
        repeat (4) step();
        sp.stall = 1'b1;
        repeat (2) step();
        sp.stall = 1'b0;
        repeat (6) step();

        // flush with stall and a new input in the same cycle
        drive(SLL, 32'h0000_0011, 5'd1, 5'd14);
        step();
        drive(SRL, 32'h0000_0022, 5'd1, 5'd15);
        step();
        drive(SRA, 32'h8000_0033, 5'd1, 5'd16);
        step();
        sp.flush = 1'b1;
        sp.stall = 1'b1;
        drive(ROTR, 32'h0000_0044, 5'd1, 5'd17);
        step();
        sp.flush = 1'b0;
        sp.stall = 1'b0;
        chk("flush_busy", {31'b0, sp.busy}, 32'h0);
        op(SLL, 32'h0000_0005, 5'd3, 5'd18, 32'h0000_0028);
        idle();
        repeat (7) step();

        // reset with two ops in flight
        drive(SLL, 32'h0000_0100, 5'd1, 5'd19);
        step();
        drive(SRL, 32'h0000_0100, 5'd1, 5'd22);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, sp.out_valid}, 32'h0);
        chk("midrst_busy", {31'b0, sp.busy}, 32'h0);
        op(SRA, 32'hF000_0000, 5'd8, 5'd23, 32'hFFF0_0000);
        idle();
        repeat (7) step();

        // zero shift in every mode
        op(SLL,  32'hDEAD_BEEF, 5'd0, 5'd24, 32'hDEAD_BEEF);
        op(SRL,  32'hDEAD_BEEF, 5'd0, 5'd25, 32'hDEAD_BEEF);
        op(SRA,  32'hDEAD_BEEF, 5'd0, 5'd26, 32'hDEAD_BEEF);
        op(ROTR, 32'hDEAD_BEEF, 5'd0, 5'd27, 32'hDEAD_BEEF);
        idle();
        repeat (8) step();

        chk("scoreboard_drained", q.size(), 32'h0);
        chk("final_busy", {31'b0, sp.busy}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
